trdb_branch_tracker: RTL
========================

# trdb_branch_tracker

Parametrised branch-history tracker for the trace encoder. It follows the retired-instruction stream and resolves each conditional branch as taken or not-taken by comparing its address with the next retired address. Resolved outcomes accumulate in a branch map of configurable depth. The block emits a registered packet under valid/ready handshake when the map fills, when an unpredictable discontinuity resolves, or on an explicit flush. It sits between instruction qualification and packet formatting.

## Interface
- XLEN, 32: instruction address width.
- BMAP_LEN, 31: branch map depth in bits, legal range 1..31.
- CW, $clog2(BMAP_LEN+1): width of the branch count (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- ivalid_i  in  1  one qualified instruction retires this cycle.
- iaddr_i  in  XLEN  address of the retiring instruction.
- compressed_i  in  1  retiring instruction is 16-bit.
- is_branch_i  in  1  retiring instruction is a conditional branch.
- u_discontinuity_i  in  1  retiring instruction is jalr/mret/sret/uret.
- flush_i  in  1  request to emit the current map now.
- packet_valid_o  out  1  packet register holds a packet.
- packet_ready_i  in  1  consumer accepts the packet.
- packet_map_o  out  BMAP_LEN  branch outcomes; bit i is the i-th resolved branch; 1 = taken.
- packet_cnt_o  out  CW  number of valid bits in packet_map_o.
- packet_addr_o  out  XLEN  associated address; meaning depends on the reason.
- packet_reason_o  out  2  2'd0 FULL, 2'd1 DISC, 2'd2 FLUSH; 2'd3 never driven.
- stall_o  out  1  packet_valid_o && !packet_ready_i.
- overflow_o  out  1  sticky flag: input was dropped.

## Operation
- State:
  - map[BMAP_LEN-1:0] and cnt[CW-1:0].
  - br_pend flag, with br_addr and br_comp.
  - disc_pend flag.
  - flush_pend flag.
  - last_addr: the last retired address.
  - the output packet register.
- Branch resolution: on ivalid_i with br_pend=1:
  - taken = (iaddr_i != br_addr + (br_comp ? 2 : 4)), computed modulo 2^XLEN.
  - map[cnt] <= taken; cnt <= cnt+1; br_pend <= 0.
- If the retiring instruction has is_branch_i=1: br_pend <= 1, br_addr <= iaddr_i, br_comp <= compressed_i. This update applies after any resolution done in the same cycle.
- FULL: when a resolution makes cnt reach BMAP_LEN, load a packet with:
  - map including the new bit, cnt = BMAP_LEN;
  - addr = iaddr_i (the resolving instruction);
  - reason FULL.
  The internal map/cnt clear on the same edge.
- DISC: on ivalid_i with disc_pend=1, load a packet with:
  - current map and cnt (cnt may be 0);
  - addr = iaddr_i (the discontinuity target);
  - reason DISC.
  Map/cnt clear and disc_pend <= 0.
- A retiring instruction with u_discontinuity_i=1 sets disc_pend <= 1.
- FULL and DISC never trigger in the same cycle: a pending branch and a pending discontinuity come from different predecessor instructions.
- FLUSH: load a packet with current map/cnt, addr = last_addr, reason FLUSH. Map/cnt clear. An unresolved br_pend is kept and resolves into the next map.
  - A flush always emits, even with cnt=0.
  - If flush_i arrives in the same cycle as an ivalid_i that loads FULL/DISC, set flush_pend. The FLUSH packet is then loaded on the next non-stalled cycle.
- Stall: while stall_o=1, ivalid_i and flush_i are ignored. Any assertion of either sets overflow_o=1 until reset.
- The packet register loads only when it is empty or being accepted in the same cycle (packet_valid_o && packet_ready_i).

## Timing
- Reset values:
  - all outputs 0; packet_valid_o=0, stall_o=0, overflow_o=0;
  - map=0, cnt=0;
  - br_pend, disc_pend, flush_pend all 0;
  - last_addr=0.
- Latency: a packet is visible one cycle after the triggering ivalid_i/flush_i edge.
- Handshake:
  - packet fields are stable while packet_valid_o && !packet_ready_i;
  - a transfer occurs on a cycle with valid && ready;
  - back-to-back packets are sustained at one per cycle with ready held high.
- A deferred FLUSH appears one cycle after the FULL/DISC packet, provided that packet is accepted.
- Reset mid-operation: the pending packet, flags and map are discarded on the next edge. There is no partial emission.

## Test plan
- BMAP_LEN=4, ready=1. Retire branch@0x100, then 0x104, then branch@0x200, then 0x300 → no packet; cnt=2; map bits [0]=0, [1]=1.
- BMAP_LEN=4: four branches resolve taken,notT,T,T; the fourth resolves at 0x480 → next cycle: valid, reason FULL, map=4'b1101, cnt=4, addr=0x480; internal cnt=0.
- jalr@0x1000, then 0x2000 retires → DISC packet with addr=0x2000 and cnt=0; a second consecutive instruction emits nothing.
- Compressed branch@0xFFFF_FFFE, next at 0x0000_0000 → wraps, not taken, bit=0.
- Hold ready=0 with a packet present; drive ivalid_i → stall_o=1, overflow_o=1, packet fields unchanged. Release ready → one transfer; overflow_o stays 1.
- flush_i together with the 4th resolving branch → FULL packet at cycle t+1, FLUSH packet (cnt=0, addr=last_addr) at t+2.
- rst_i asserted with disc_pend=1 and a packet valid → next cycle all outputs 0; the next retirement emits no DISC.

Source files
------------

// File: rtl/trdb_branch_tracker.sv
// trdb_branch_tracker: resolves conditional branches in the retired stream
// into a branch map and emits FULL / DISC / FLUSH packets over valid/ready.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ivalid_i, iaddr_i       one retired instruction and its address
//   compressed_i            retiring instruction is 16-bit
//   is_branch_i             retiring instruction is a conditional branch
//   u_discontinuity_i       retiring instruction is jalr/mret/sret/uret
//   flush_i                 emit the current map now
//   packet_*_o / _ready_i   registered output packet and handshake
//   stall_o                 packet held and not accepted; inputs ignored
//   overflow_o              sticky: input arrived while stalled
module trdb_branch_tracker #(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned BMAP_LEN = 31,
    localparam int unsigned CW       = $clog2(BMAP_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ivalid_i,
    input  logic [XLEN-1:0]     iaddr_i,
    input  logic                compressed_i,
    input  logic                is_branch_i,
    input  logic                u_discontinuity_i,
    input  logic                flush_i,
    output logic                packet_valid_o,
    input  logic                packet_ready_i,
    output logic [BMAP_LEN-1:0] packet_map_o,
    output logic [CW-1:0]       packet_cnt_o,
    output logic [XLEN-1:0]     packet_addr_o,
    output logic [1:0]          packet_reason_o,
    output logic                stall_o,
    output logic                overflow_o
);

    typedef enum logic [1:0] {
        RSN_FULL  = 2'd0,
        RSN_DISC  = 2'd1,
        RSN_FLUSH = 2'd2
    } reason_e;

    logic [BMAP_LEN-1:0] map_q, map_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                br_pend_q, br_pend_d;
    logic [XLEN-1:0]     br_addr_q, br_addr_d;
    logic                br_comp_q, br_comp_d;
    logic                disc_pend_q, disc_pend_d;
    logic                flush_pend_q, flush_pend_d;
    logic [XLEN-1:0]     last_addr_q, last_addr_d;
    logic                ovf_q, ovf_d;

    logic                pkt_valid_q, pkt_valid_d;
    logic [BMAP_LEN-1:0] pkt_map_q, pkt_map_d;
    logic [CW-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic [XLEN-1:0]     pkt_addr_q, pkt_addr_d;
    reason_e             pkt_rsn_q, pkt_rsn_d;

    logic                stall;
    logic                iv;
    logic                fl;
    logic                resolve;
    logic                taken;
    logic [XLEN-1:0]     br_next;
    logic [BMAP_LEN-1:0] map_res;
    logic [CW-1:0]       cnt_res;
    logic                full;
    logic                disc;
    logic                want_flush;

    always_comb begin
        stall      = pkt_valid_q && !packet_ready_i;
        iv         = ivalid_i && !stall;
        fl         = flush_i && !stall;
        // Sequential successor of the pending branch, wraps modulo 2^XLEN.
        br_next    = br_addr_q + (br_comp_q ? XLEN'(2) : XLEN'(4));
        resolve    = iv && br_pend_q;
        taken      = (iaddr_i != br_next);
        map_res    = map_q;
        cnt_res    = cnt_q;
        if (resolve) begin
            map_res = map_q | (BMAP_LEN'(taken) << cnt_q);
            cnt_res = cnt_q + CW'(1);
        end
        full       = resolve && (cnt_res == CW'(BMAP_LEN));
        disc       = iv && disc_pend_q;
        want_flush = !stall && (fl || flush_pend_q);

        map_d        = map_res;
        cnt_d        = cnt_res;
        br_pend_d    = br_pend_q;
        br_addr_d    = br_addr_q;
        br_comp_d    = br_comp_q;
        disc_pend_d  = disc_pend_q;
        flush_pend_d = flush_pend_q;
        last_addr_d  = iv ? iaddr_i : last_addr_q;
        ovf_d        = ovf_q | (stall && (ivalid_i || flush_i));

        pkt_valid_d  = pkt_valid_q && !packet_ready_i;
        pkt_map_d    = pkt_map_q;
        pkt_cnt_d    = pkt_cnt_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_rsn_d    = pkt_rsn_q;

        if (full || disc) begin
            pkt_valid_d  = 1'b1;
            pkt_map_d    = map_res;
            pkt_cnt_d    = cnt_res;
            pkt_addr_d   = iaddr_i;
            pkt_rsn_d    = full ? RSN_FULL : RSN_DISC;
            map_d        = '0;
            cnt_d        = '0;
            // A coincident flush is deferred to the next free cycle.
            flush_pend_d = want_flush;
        end else if (want_flush) begin
            pkt_valid_d  = 1'b1;
            pkt_map_d    = map_res;
            pkt_cnt_d    = cnt_res;
            pkt_addr_d   = last_addr_d;
            pkt_rsn_d    = RSN_FLUSH;
            map_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end

        if (disc) begin
            disc_pend_d = 1'b0;
        end
        if (iv && u_discontinuity_i) begin
            disc_pend_d = 1'b1;
        end

        if (resolve) begin
            br_pend_d = 1'b0;
        end
        if (iv && is_branch_i) begin
            br_pend_d = 1'b1;
            br_addr_d = iaddr_i;
            br_comp_d = compressed_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q        <= '0;
            cnt_q        <= '0;
            br_pend_q    <= 1'b0;
            br_addr_q    <= '0;
            br_comp_q    <= 1'b0;
            disc_pend_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            last_addr_q  <= '0;
            ovf_q        <= 1'b0;
            pkt_valid_q  <= 1'b0;
            pkt_map_q    <= '0;
            pkt_cnt_q    <= '0;
            pkt_addr_q   <= '0;
            pkt_rsn_q    <= RSN_FULL;
        end else begin
            map_q        <= map_d;
            cnt_q        <= cnt_d;
            br_pend_q    <= br_pend_d;
            br_addr_q    <= br_addr_d;
            br_comp_q    <= br_comp_d;
            disc_pend_q  <= disc_pend_d;
            flush_pend_q <= flush_pend_d;
            last_addr_q  <= last_addr_d;
            ovf_q        <= ovf_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_map_q    <= pkt_map_d;
            pkt_cnt_q    <= pkt_cnt_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_rsn_q    <= pkt_rsn_d;
        end
    end

    assign packet_valid_o  = pkt_valid_q;
    assign packet_map_o    = pkt_map_q;
    assign packet_cnt_o    = pkt_cnt_q;
    assign packet_addr_o   = pkt_addr_q;
    assign packet_reason_o = pkt_rsn_q;
    assign stall_o         = stall;
    assign overflow_o      = ovf_q;

endmodule
